keypad_scan4x4: RTL
===================

// Module: keypad_scan4x4
// PURPOSE
//   Scans a 4x4 matrix keypad and reports debounced key presses as a 4-bit hex
//   code with a one-cycle valid strobe. It is the input-side companion of the
//   multiplexed seven-segment driver: it drives one active-low row at a time
//   and reads the active-low columns. Its key codes feed game control and CPU
//   I/O registers.
// PARAMETERS
//   SCAN_DIV        16  cclk cycles per row slot (>=4); columns sampled in last cycle of slot
//   DEBOUNCE_SCANS   4  consecutive identical full-scan results to accept press/release (>=1, <=15)
// PORTS
//   cclk       in   1  system clock; all logic on posedge
//   clrn       in   1  synchronous active-low reset
//   row        out  4  row drive, active-low, exactly one bit low at a time
//   col        in   4  column sense, active-low (board pull-ups), asynchronous
//   key        out  4  last accepted key code = row_idx*4 + col_idx
//   key_valid  out  1  one-cycle pulse when a new press is accepted
//   key_held   out  1  high from acceptance until debounced release
// BEHAVIOUR
//   Reset (clrn=0 at posedge): row=4'b1110, key=0, key_valid=0, key_held=0,
//     FSM=IDLE, slot counter=0, row_idx=0, debounce count=0, scan result=none.
//   Sync: col passes through 2 flops (col_s) before any use; values are inverted internally (pressed=1).
//   Scan: slot counter 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps and row_idx advances
//     0->1->2->3->0. row = ~(4'b0001 << row_idx). On the last cycle of each slot,
//     col_s is sampled for the current row_idx.
//   Per-scan priority: within one full scan (rows 0..3) the lowest code wins, meaning
//     the lowest row and then the lowest column. One scan result (none | code) is produced
//     when row 3's sample is taken; the accumulator is then cleared for the next scan.
//   FSM advances only on scan-result cycles (one cycle per 4*SCAN_DIV):
//     IDLE:        key -> cand=code, cnt=1, PRESS_CHK (if DEBOUNCE_SCANS==1, accept at once).
//                  none -> stay.
//     PRESS_CHK:   same code -> cnt+1; when cnt reaches DEBOUNCE_SCANS, key<=cand,
//                  key_valid=1 for that cycle only, go to HELD. Different code -> restart with
//                  the new cand and cnt=1. None -> IDLE.
//     HELD:        key_held=1. None -> cnt=1, REL_CHK. Any key, including a different one,
//                  -> stay. No rollover; a second key is ignored until full release.
//     REL_CHK:     key_held stays 1. None -> cnt+1; at DEBOUNCE_SCANS -> IDLE, key_held=0.
//                  Any key -> HELD, with no new key_valid.
//   key holds its value after release until the next accepted press.
//   key_valid is never asserted in consecutive cycles. Its minimum spacing is
//     2*DEBOUNCE_SCANS scans.
//   Latency: for a key stable before a scan starts, key_valid fires on the result cycle of
//     scan DEBOUNCE_SCANS, i.e. <= (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 2 cycles after col changes.
//   Reset mid-operation: all state returns to reset values on that edge. No pulse is emitted,
//     and a press in progress must be re-debounced in full.
//   All counters are sized to their max value and wrap naturally. No X on outputs after reset.
// TESTING  (SCAN_DIV=4, DEBOUNCE_SCANS=3; one scan = 16 cycles)
//   1 Reset, no keys, 200 cycles -> row cycles 1110,1101,1011,0111 every 4 cycles;
//     key_valid never 1; key=0.
//   2 Hold key row2/col1 (col=4'b1101 while row=1011) -> exactly one key_valid pulse,
//     key=4'h9, key_held=1; release -> key_held=0 after 3 clean scans.
//   3 Bounce: toggle the row0/col0 press every 10 cycles for 100 cycles, then hold ->
//     no pulse during the bounce; one pulse with key=0 after 3 stable scans.
//   4 Press row1/col3 and row3/col0 together -> key=4'h7 (lowest code); while held,
//     release row1/col3 -> no new pulse, key_held stays 1.
//   5 Press 4'hF, then 1 clean scan, then re-press -> no second key_valid (REL_CHK->HELD);
//     full release then press 4'h5 -> pulse, key=5.
//   6 clrn=0 for 1 cycle while in PRESS_CHK with a key held -> outputs are at reset values;
//     pulse arrives 3 full scans later.

Source files
------------

// File: rtl/keypad_scan4x4.sv
// keypad_scan4x4: 4x4 matrix keypad scanner with per-scan priority encoding
// and scan-level debounce. Drives one active-low row at a time, reads the
// active-low columns through a two-flop synchronizer, and reports accepted
// presses as a hex code with a one-cycle valid strobe plus a held flag.
module keypad_scan4x4 #(
    parameter int SCAN_DIV       = 16,  // cclk cycles per row slot (>= 4)
    parameter int DEBOUNCE_SCANS = 4    // identical full scans to accept (1..15)
) (
    input  logic       cclk,
    input  logic       clrn,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int                SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [3:0]        DEB_N     = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } state_t;

    // Registered state
    logic [3:0]        col_meta_q;
    logic [3:0]        col_s_q;
    logic [SLOT_W-1:0] slot_q,      slot_d;
    logic [1:0]        row_idx_q,   row_idx_d;
    logic [3:0]        row_q,       row_d;
    logic              acc_found_q, acc_found_d;
    logic [3:0]        acc_code_q,  acc_code_d;
    state_t            state_q,     state_d;
    logic [3:0]        cnt_q,       cnt_d;
    logic [3:0]        cand_q,      cand_d;
    logic [3:0]        key_q,       key_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q,  key_held_d;

    // Scan-result signals, valid on the cycle row 3 is sampled
    logic [3:0] pressed;
    logic [1:0] col_idx;
    logic       scan_done;
    logic       scan_found;
    logic [3:0] scan_code;

    // Columns are active-low on the board; invert so a pressed key reads 1.
    assign pressed = ~col_s_q;

    // Lowest pressed column in the current row wins.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        col_idx = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (pressed[c]) col_idx = 2'(c);
        end
    end

    // Slot/row sequencing and the per-scan lowest-code accumulator.
    always_comb begin
        slot_d      = slot_q + 1'b1;
        row_idx_d   = row_idx_q;
        acc_found_d = acc_found_q;
        acc_code_d  = acc_code_q;
        scan_done   = 1'b0;
        scan_found  = acc_found_q;
        scan_code   = acc_code_q;
        if (slot_q == SLOT_LAST) begin
            slot_d    = '0;
            row_idx_d = row_idx_q + 2'd1;
            // Rows arrive in ascending order, so the first hit of a scan is the lowest row.
            if (!acc_found_q && (|pressed)) begin
                scan_found = 1'b1;
                scan_code  = {row_idx_q, col_idx};
            end
            if (row_idx_q == 2'd3) begin
                scan_done   = 1'b1;
                acc_found_d = 1'b0;
                acc_code_d  = 4'd0;
            end else begin
                acc_found_d = scan_found;
                acc_code_d  = scan_code;
            end
        end
        row_d = ~(4'b0001 << row_idx_d);
    end

    // Debounce FSM next-state; it only moves on scan-result cycles.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        if (scan_done) begin
            case (state_q)
                IDLE: begin
                    if (scan_found) begin
                        cand_d = scan_code;
                        cnt_d  = 4'd1;
                        if (DEB_N == 4'd1) begin
                            key_d       = scan_code;
                            key_valid_d = 1'b1;
                            state_d     = HELD;
                        end else begin
                            state_d = PRESS_CHK;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (!scan_found) begin
                        state_d = IDLE;
                    end else if (scan_code == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == DEB_N) begin
                            key_d       = cand_q;
                            key_valid_d = 1'b1;
                            state_d     = HELD;
                        end
                    end else begin
                        cand_d = scan_code;
                        cnt_d  = 4'd1;
                    end
                end
                HELD: begin
                    // No rollover: any key, even a different one, keeps us here.
                    if (!scan_found) begin
                        cnt_d   = 4'd1;
                        state_d = (DEB_N == 4'd1) ? IDLE : REL_CHK;
                    end
                end
                REL_CHK: begin
                    if (scan_found) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == DEB_N) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        key_held_d = (state_d == HELD) || (state_d == REL_CHK);
    end

    // All registers, including the column synchronizer, with synchronous reset.
    always_ff @(posedge cclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (!clrn) begin
            col_meta_q  <= 4'hF;
            col_s_q     <= 4'hF;
            slot_q      <= '0;
            row_idx_q   <= 2'd0;
            row_q       <= 4'b1110;
            acc_found_q <= 1'b0;
            acc_code_q  <= 4'd0;
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            cand_q      <= 4'd0;
            key_q       <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            col_meta_q  <= col;
            col_s_q     <= col_meta_q;
            slot_q      <= slot_d;
            row_idx_q   <= row_idx_d;
            row_q       <= row_d;
            acc_found_q <= acc_found_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign row       = row_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
